// File: rtl/aes_round_ctrl_if.sv
// Handshake and round-control bundle between the AES top level and its round controller.
// The master drives requests; the slave (controller) drives sequencing outputs.
interface aes_round_ctrl_if #(
    parameter int unsigned NR_MAX = 14,
    parameter int unsigned RW     = 4
);
    logic              start;
    logic [1:0]        key_len;
    logic              decrypt;
    logic              key_new;
    logic              busy;
    logic              done;
    logic              key_valid;
    logic [NR_MAX:0]   rk_en;
    logic [RW-1:0]     rk_sel;
    logic [RW-1:0]     round;
    logic              sel_init;
    logic              sel_final;
    logic              state_en;

    modport master (
        output start, key_len, decrypt, key_new,
        input  busy, done, key_valid, rk_en, rk_sel, round, sel_init, sel_final, state_en
    );

    modport slave (
        input  start, key_len, decrypt, key_new,
        output busy, done, key_valid, rk_en, rk_sel, round, sel_init, sel_final, state_en
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128/192/256 round controller: sequences key expansion into per-round key buffers,
// then steps the datapath through initial AddRoundKey, middle rounds and final round.
module aes_round_ctrl #(
    parameter int unsigned NR_MAX = 14,
    parameter int unsigned RW     = 4
) (
    input logic               clk,
    input logic               reset,
    aes_round_ctrl_if.slave   bus_io
);

    localparam int unsigned NK = NR_MAX + 1;

    typedef enum logic [2:0] {StIdle, StKexp, StInit, StRound, StFinal, StDone} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   cnt_q, cnt_d;
    logic            key_valid_q, key_valid_d;
    logic            pending_q, pending_d;
    logic [1:0]      klen_q, klen_d;
    logic            dec_q, dec_d;
    logic [1:0]      elen_q, elen_d;
    logic [RW-1:0]   nr;
    logic [1:0]      start_len;

    // Unsupported or unused encodings fall back to AES-128.
    function automatic logic [1:0] norm_len(input logic [1:0] kl);
        logic [1:0] l;
        l = (kl == 2'b11) ? 2'b00 : kl;
        if (l == 2'b01 && NR_MAX < 12) l = 2'b00;
        if (l == 2'b10 && NR_MAX < 14) l = 2'b00;
        return l;
    endfunction

    always_comb begin
        case (klen_q)
            2'b01:   nr = RW'(12);
            2'b10:   nr = RW'(14);
            default: nr = RW'(10);
        endcase
    end

    assign start_len = norm_len(bus_io.key_len);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_valid_d = key_valid_q;
        pending_d   = pending_q | bus_io.key_new;
        klen_d      = klen_q;
        dec_d       = dec_q;
        elen_d      = elen_q;

        bus_io.busy      = 1'b0;
        bus_io.done      = 1'b0;
        bus_io.rk_en     = '0;
        bus_io.rk_sel    = '0;
        bus_io.round     = '0;
        bus_io.sel_init  = 1'b0;
        bus_io.sel_final = 1'b0;
        bus_io.state_en  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    klen_d = start_len;
                    dec_d  = bus_io.decrypt;
                    cnt_d  = '0;
                    if (pending_q || !key_valid_q || (start_len != elen_q)) begin
                        // Buffers are about to be overwritten; a key_new seen now still counts.
                        state_d     = StKexp;
                        key_valid_d = 1'b0;
                        pending_d   = bus_io.key_new;
                    end else begin
                        state_d = StInit;
                    end
                end
            end
            StKexp: begin
                bus_io.busy  = 1'b1;
                bus_io.rk_en = NK'(1) << cnt_q;
                if (cnt_q >= nr) begin
                    key_valid_d = 1'b1;
                    elen_d      = klen_q;
                    cnt_d       = '0;
                    state_d     = StInit;
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            StInit: begin
                bus_io.busy     = 1'b1;
                bus_io.sel_init = 1'b1;
                bus_io.state_en = 1'b1;
                bus_io.rk_sel   = dec_q ? nr : '0;
                cnt_d           = RW'(1);
                state_d         = StRound;
            end
            StRound: begin
                bus_io.busy     = 1'b1;
                bus_io.state_en = 1'b1;
                bus_io.round    = cnt_q;
                bus_io.rk_sel   = dec_q ? (nr - cnt_q) : cnt_q;
                if (cnt_q >= nr - RW'(1)) begin
                    state_d = StFinal;
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            StFinal: begin
                bus_io.busy      = 1'b1;
                bus_io.sel_final = 1'b1;
                bus_io.state_en  = 1'b1;
                bus_io.round     = nr;
                bus_io.rk_sel    = dec_q ? '0 : nr;
                cnt_d            = '0;
                state_d          = StDone;
            end
            StDone: begin
                bus_io.done = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_io.key_valid = key_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            pending_q   <= 1'b0;
            klen_q      <= 2'b00;
            dec_q       <= 1'b0;
            elen_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            pending_q   <= pending_d;
            klen_q      <= klen_d;
            dec_q       <= dec_d;
            elen_q      <= elen_d;
        end
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Parametrised AES control FSM covering AES-128, AES-192 and AES-256. It sequences round-key expansion into per-round key buffers through one-hot write enables, then steps the cipher datapath through the initial AddRoundKey, the middle rounds and the final round. It supports encrypt and decrypt ordering, skips re-expansion when the key is unchanged, and exposes a start/busy/done handshake to the top level.

Parameters:
NR_MAX, 14, highest supported round count. Legal values are 10, 12 and 14. Round-key buffer count is NR_MAX+1.
RW, 4, width of the round and rk_sel outputs. Must satisfy 2**RW > NR_MAX.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request one block operation; sampled only in IDLE
key_len  in  2  00 = 128 (Nr 10), 01 = 192 (Nr 12), 10 = 256 (Nr 14), 11 = treated as 00
decrypt  in  1  0 = encrypt, 1 = decrypt; latched on accepted start
key_new  in  1  single-cycle pulse: new cipher key loaded, expansion required
busy  out  1  operation in progress
done  out  1  single-cycle pulse, result valid
key_valid  out  1  round-key buffers hold a complete expansion
rk_en  out  NR_MAX+1  one-hot write enable for round-key buffer k during expansion
rk_sel  out  RW  index of the round key applied this cycle
round  out  RW  current cipher round, 0..Nr
sel_init  out  1  initial AddRoundKey cycle; datapath takes input block
sel_final  out  1  final round; MixColumns bypassed
state_en  out  1  state register load enable

Behaviour:
- States: IDLE, KEXP, INIT, ROUND, FINAL, DONE. On reset: state = IDLE; all outputs = 0; key_valid = 0; pending-key flag = 0; latched length/mode = 0.
- Nr = 10/12/14 from the latched key_len. A key_len whose Nr exceeds NR_MAX is treated as 00.
- key_new pulse in any state sets the pending flag. It never aborts an operation in flight.
- IDLE + start: latch key_len and decrypt, then:
  - go to KEXP if the pending flag is set, key_valid = 0, or the latched key_len differs from the stored expansion length;
  - otherwise go to INIT.
- KEXP: counter k runs 0..Nr, one cycle each, with rk_en[k] = 1 for that cycle only (Nr+1 cycles total). On the cycle after k = Nr: key_valid = 1, store the expansion length, clear the pending flag, go to INIT.
- If key_new arrives during KEXP, the flag stays set after completion and the next start re-expands.
- INIT (1 cycle): sel_init = 1, state_en = 1, round = 0, rk_sel = decrypt ? Nr : 0.
- ROUND: round r = 1..Nr-1, one cycle each. state_en = 1, rk_sel = decrypt ? Nr-r : r.
- FINAL (1 cycle): round = Nr, sel_final = 1, state_en = 1, rk_sel = decrypt ? 0 : Nr.
- DONE (1 cycle): done = 1, busy = 0, then IDLE. A start asserted during DONE is ignored.
- busy = 1 in KEXP, INIT, ROUND and FINAL. Outputs not named for a state are 0 in that state.
- Latency with a valid key: start sampled at edge T; INIT at T+1; rounds at T+2..T+Nr; FINAL at T+Nr+1; done at T+Nr+2. A preceding expansion adds Nr+1 cycles.
- start, key_len and decrypt changes while busy have no effect.
- Reset asserted mid-operation: the next edge returns to IDLE with all outputs 0 and key_valid = 0, so the next start re-expands.
- Round and key counters saturate; they never wrap past Nr.

Test Plan:
- Reset, key_new pulse, start with key_len = 00, decrypt = 0 -> rk_en = 0x0001, 0x0002, … 0x0400 over 11 cycles. Then INIT with rk_sel 0, rounds 1..9 with rk_sel = r, FINAL with rk_sel 10. done 23 cycles after start; key_valid = 1.
- Second start, same key_len, no key_new -> no rk_en activity; done exactly 12 cycles after start.
- key_len = 10, decrypt = 1, after a valid 128-bit expansion -> length mismatch forces KEXP of 15 cycles (rk_en up to bit 14). Cipher rk_sel sequence is 14, 13, … 0 with sel_final on rk_sel 0; done 31 cycles after start.
- key_len = 01 with key_new pulsed mid-cipher -> current block completes in 12+1 cipher cycles without disturbance. The next start performs a 13-cycle KEXP.
- Reset asserted during the ROUND state at round 5 -> next cycle busy = 0, round = 0, key_valid = 0. The following start performs a full expansion.
- key_len = 11, plus start pulsed while busy and during DONE -> behaves exactly as AES-128. Extra start pulses produce no second operation.
